counter_enable_prescaler: RTL and testbench

- Upstream enable generator for the synchronous up-counter (`counter_up_sync_beh_32` family).
- Divides `clk` by a programmable ratio and produces a single-cycle `enable` strobe for the counter's `enable` input.
- Supports free-running (continuous) operation and a burst mode that emits a fixed number of strobes, then signals completion.
- Lets the counter advance at a controlled rate or by an exact number of counts.

---
 rtl/counter_enable_prescaler.sv | 150 +++++++++++++++
 tb/tb_counter_enable_prescaler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_enable_prescaler.sv
// ---------------------------------------------------------------------------
// counter_enable_prescaler
//
// Purpose:
//   Enable generator for a synchronous up-counter. It divides clk by a
//   programmable ratio (div+1) and emits a single-cycle, registered enable
//   strobe. It runs in one of two modes:
//     - continuous: free-running until stop or reset
//     - burst:      emits burst_len strobes, then pulses done
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin request, sampled only while idle
//   stop        in   abort request, sampled only while running
//   mode        in   0 = continuous, 1 = burst (captured at start)
//   div         in   divide ratio minus one (captured at start)
//   burst_len   in   strobes per burst (captured at start)
//   enable      out  registered strobe to the counter
//   busy        out  high while running
//   done        out  one-cycle pulse at burst completion
//   pulse_count out  strobes emitted since the last accepted start
// ---------------------------------------------------------------------------
module counter_enable_prescaler #(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [BURST_WIDTH-1:0] burst_len,
    output logic                   enable,
    output logic                   busy,
    output logic                   done,
    output logic [BURST_WIDTH-1:0] pulse_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [DIV_WIDTH-1:0]   div_q_r;
    logic [BURST_WIDTH-1:0] len_q_r;
    logic                   mode_q_r;
    logic [DIV_WIDTH-1:0]   presc_r;
    logic [BURST_WIDTH-1:0] pulse_count_r;
    logic                   enable_r;
    logic                   busy_r;
    logic                   done_r;

    logic [BURST_WIDTH-1:0] next_count_s;
    logic                   last_strobe_s;
    logic                   zero_burst_s;

    // Strobe count after the current strobe and the burst-termination tests
    always_comb begin
        next_count_s  = pulse_count_r + BURST_WIDTH'(1);
        last_strobe_s = mode_q_r && (next_count_s == len_q_r);
        zero_burst_s  = mode && (burst_len == {BURST_WIDTH{1'b0}});
    end

    // Control FSM, prescaler, strobe counter and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            div_q_r       <= {DIV_WIDTH{1'b0}};
            len_q_r       <= {BURST_WIDTH{1'b0}};
            mode_q_r      <= 1'b0;
            presc_r       <= {DIV_WIDTH{1'b0}};
            pulse_count_r <= {BURST_WIDTH{1'b0}};
            enable_r      <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    enable_r <= 1'b0;
                    // stop is ignored here; start alone decides acceptance
                    if (start) begin
                        div_q_r       <= div;
                        len_q_r       <= burst_len;
                        mode_q_r      <= mode;
                        presc_r       <= div;
                        pulse_count_r <= {BURST_WIDTH{1'b0}};
                        if (zero_burst_s) begin
                            // Empty burst completes immediately without running
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // stop outranks a strobe falling due on the same edge
                    if (stop) begin
                        state_r  <= ST_IDLE;
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b0;
                    end else if (presc_r == {DIV_WIDTH{1'b0}}) begin
                        enable_r      <= 1'b1;
                        presc_r       <= div_q_r;
                        pulse_count_r <= next_count_s;
                        if (last_strobe_s) begin
                            // Final strobe and done share the same cycle
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                            busy_r  <= 1'b1;
                            done_r  <= 1'b0;
                        end
                    end else begin
                        enable_r <= 1'b0;
                        presc_r  <= presc_r - DIV_WIDTH'(1);
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        done_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign enable      = enable_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign pulse_count = pulse_count_r;

endmodule

// File: tb/tb_counter_enable_prescaler.sv
// ---------------------------------------------------------------------------
// tb_counter_enable_prescaler
//
// Self-checking bench for counter_enable_prescaler. Expected values come from
// the strobe arithmetic: with period P = div+1, the k-th cycle after the
// accepted start carries a strobe when k is a multiple of P, the strobe count
// is k/P, and a burst of L strobes ends at cycle L*P.
// ---------------------------------------------------------------------------
module tb_counter_enable_prescaler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] div;
    logic [15:0] burst_len;
    logic        enable;
    logic        busy;
    logic        done;
    logic [15:0] pulse_count;

    int n_tests = 0;
    int n_fail  = 0;

    counter_enable_prescaler #(
        .DIV_WIDTH   (16),
        .BURST_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .div         (div),
        .burst_len   (burst_len),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are observed 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0;
        div = 16'd0; burst_len = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({enable, busy, done, pulse_count} !== {1'b0, 1'b0, 1'b0, 16'd0}) begin
                $display("FAIL reset_outputs edge %0d: got en=%b busy=%b done=%b cnt=%0d, want all 0",
                         i, enable, busy, done, pulse_count);
                n_fail++;
            end
        end
        reset = 1'b0; start = 1'b0;
        tick();
        n_tests++;
        if ({enable, busy, done} !== 3'b000) begin
            $display("FAIL reset_release_idle: got en=%b busy=%b done=%b, want 000", enable, busy, done);
            n_fail++;
        end
    endtask

    task automatic test_continuous();
        mode = 1'b0; div = 16'd3; burst_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        div = 16'd9;   // must not affect the running configuration
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_tests++;
            if ({enable, busy, done} !== {((k % 4) == 0), 1'b1, 1'b0}) begin
                $display("FAIL continuous k=%0d: got en=%b busy=%b done=%b, want en=%b busy=1 done=0",
                         k, enable, busy, done, ((k % 4) == 0));
                n_fail++;
            end
        end
        n_tests++;
        if (pulse_count !== 16'd3) begin
            $display("FAIL continuous_count: got %0d want 3", pulse_count);
            n_fail++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if ({enable, busy, done, pulse_count} !== {3'b000, 16'd3}) begin
            $display("FAIL continuous_stop: got en=%b busy=%b done=%b cnt=%0d want 000 cnt=3",
                     enable, busy, done, pulse_count);
            n_fail++;
        end
    endtask

    task automatic test_full_rate();
        mode = 1'b0; div = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_tests++;
            if ({enable, busy, pulse_count} !== {2'b11, 16'(k)}) begin
                $display("FAIL full_rate k=%0d: got en=%b busy=%b cnt=%0d want en=1 busy=1 cnt=%0d",
                         k, enable, busy, pulse_count, k);
                n_fail++;
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_tests++;
        if ({enable, busy, pulse_count} !== {2'b00, 16'd5}) begin
            $display("FAIL full_rate_stop: got en=%b busy=%b cnt=%0d want 00 cnt=5", enable, busy, pulse_count);
            n_fail++;
        end
    endtask

    task automatic test_burst();
        mode = 1'b1; div = 16'd1; burst_len = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            // a start while running, with a different config, must be ignored
            start = (k == 3); div = (k == 3) ? 16'd0 : 16'd1; burst_len = (k == 3) ? 16'd1 : 16'd3;
            tick();
            n_tests++;
            if ({enable, busy, done, pulse_count} !== {((k % 2) == 0), (k < 6), (k == 6), 16'(k / 2)}) begin
                $display("FAIL burst k=%0d: got en=%b busy=%b done=%b cnt=%0d want en=%b busy=%b done=%b cnt=%0d",
                         k, enable, busy, done, pulse_count, ((k % 2) == 0), (k < 6), (k == 6), k / 2);
                n_fail++;
            end
        end
        start = 1'b0;
        tick();
        n_tests++;
        if ({enable, busy, done, pulse_count} !== {3'b000, 16'd3}) begin
            $display("FAIL burst_after: got en=%b busy=%b done=%b cnt=%0d want 000 cnt=3",
                     enable, busy, done, pulse_count);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        int done_seen;
        done_seen = 0;
        mode = 1'b1; div = 16'd2; burst_len = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            stop = (k == 6);
            tick();
            if (done) done_seen++;
        end
        stop = 1'b0;
        n_tests++;
        if ({enable, busy, done, pulse_count} !== {3'b000, 16'd1}) begin
            $display("FAIL abort_stop: got en=%b busy=%b done=%b cnt=%0d want 000 cnt=1",
                     enable, busy, done, pulse_count);
            n_fail++;
        end
        tick();
        if (done) done_seen++;
        n_tests++;
        if (done_seen !== 0) begin
            $display("FAIL abort_no_done: got %0d done cycles want 0", done_seen);
            n_fail++;
        end
        // rerun and kill with reset at the 4th edge (just after a strobe)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) tick();
        n_tests++;
        if ({enable, busy, pulse_count} !== {2'b11, 16'd1}) begin
            $display("FAIL abort_rerun: got en=%b busy=%b cnt=%0d want 11 cnt=1", enable, busy, pulse_count);
            n_fail++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if ({enable, busy, done, pulse_count} !== {3'b000, 16'd0}) begin
            $display("FAIL abort_reset: got en=%b busy=%b done=%b cnt=%0d want all 0",
                     enable, busy, done, pulse_count);
            n_fail++;
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || enable || busy) done_seen++;
        end
        n_tests++;
        if (done_seen !== 0) begin
            $display("FAIL abort_reset_quiet: got %0d active cycles want 0", done_seen);
            n_fail++;
        end
    endtask

    task automatic test_zero_burst();
        mode = 1'b1; div = 16'd2; burst_len = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_tests++;
        if ({enable, busy, done, pulse_count} !== {3'b001, 16'd0}) begin
            $display("FAIL zero_burst_done: got en=%b busy=%b done=%b cnt=%0d want en=0 busy=0 done=1 cnt=0",
                     enable, busy, done, pulse_count);
            n_fail++;
        end
        tick();
        n_tests++;
        if ({enable, busy, done} !== 3'b000) begin
            $display("FAIL zero_burst_after: got en=%b busy=%b done=%b want 000", enable, busy, done);
            n_fail++;
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int p, m, l, stop_k, end_k, exp_cnt, errs;
            p = $urandom_range(0, 5) + 1;
            m = $urandom_range(0, 1);
            l = $urandom_range(1, 5);
            stop_k = $urandom_range(1, 40);
            end_k = (m == 1) ? l * p : 1000;
            errs = 0;
            mode = m[0]; div = 16'(p - 1); burst_len = 16'(l); start = 1'b1; stop = 1'b0;
            tick();
            exp_cnt = 0;
            for (int k = 1; k <= 40; k++) begin
                // scramble config and issue starts while running; only stop matters
                start = $urandom_range(0, 1);
                div = 16'($urandom_range(0, 7));
                burst_len = 16'($urandom_range(0, 7));
                mode = $urandom_range(0, 1);
                stop = (k == stop_k);
                tick();
                if (k == stop_k) begin
                    exp_cnt = (k - 1) / p;
                    if ({enable, busy, done, pulse_count} !== {3'b000, 16'(exp_cnt)}) errs++;
                    break;
                end
                exp_cnt = k / p;
                if ({enable, busy, done, pulse_count} !==
                    {((k % p) == 0), (k != end_k), (k == end_k), 16'(exp_cnt)}) errs++;
                if (k == end_k) break;
            end
            start = 1'b0; stop = 1'b0;
            tick();
            if ({enable, busy, done, pulse_count} !== {3'b000, 16'(exp_cnt)}) errs++;
            n_tests++;
            if (errs != 0) begin
                $display("FAIL random it=%0d (P=%0d mode=%0d len=%0d stop_k=%0d): got %0d bad cycles want 0",
                         it, p, m, l, stop_k, errs);
                n_fail++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        div = 16'd0; burst_len = 16'd0;
        test_reset();
        test_continuous();
        test_full_rate();
        test_burst();
        test_abort();
        test_zero_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
